// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Optional early-out divide: MD_DIV_EARLY_EN.
// Latency MTHI/MTLO 1, MULT MUL_STAGES, DIV WIDTH+1; req_ready low while busy or flushing.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_src1,
  input  logic [WIDTH-1:0] req_src2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MTX, S_MUL, S_DIV} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_mthi, r_signed, r_dsetup, r_qneg, r_rneg, r_dz, r_early;
  logic [WIDTH-1:0]   r_a, r_b, r_rem, r_quo, r_dvs, r_hi, r_lo;
  logic [CW-1:0]      r_cnt;
  logic               r_done, r_div_zero;
  logic               w_accept, w_commit, w_early;
  logic [WIDTH-1:0]   w_hi_nxt, w_lo_nxt, w_a_abs, w_b_abs, w_rem_it, w_quo_it;
  logic [WIDTH:0]     w_shift, w_diff;
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;

  assign req_ready = (r_state == S_IDLE) && !flush;
  assign w_accept  = req_valid && req_ready;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;

  // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both signednesses.
  assign w_a_ext = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
  assign w_b_ext = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_a_abs = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_b_abs = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  // One restoring step: the remainder always stays below the divisor, so WIDTH bits suffice.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_rem_it = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_it = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

`ifdef MD_DIV_EARLY_EN
  assign w_early = (r_b == '0) || (w_a_abs < w_b_abs);
`else
  assign w_early = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (req_op)
            OP_MULT: w_state_nxt = S_MUL;
            OP_DIV:  w_state_nxt = S_DIV;
            default: w_state_nxt = S_MTX;
          endcase
        end
      end
      S_MTX: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
        if (r_mthi) w_hi_nxt = r_a;
        else        w_lo_nxt = r_a;
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
          w_hi_nxt    = w_prod[2*WIDTH-1:WIDTH];
          w_lo_nxt    = w_prod[WIDTH-1:0];
        end
      end
      S_DIV: begin
        if (!r_dsetup && (r_early || r_cnt == '0)) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
          if (r_early) begin
            w_hi_nxt = r_a;
            w_lo_nxt = r_dz ? '1 : '0;
          end else begin
            w_hi_nxt = r_dz ? r_a : (r_rneg ? -w_rem_it : w_rem_it);
            w_lo_nxt = r_dz ? '1  : (r_qneg ? -w_quo_it : w_quo_it);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_commit    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_commit;
      if (w_commit) begin
        r_hi       <= w_hi_nxt;
        r_lo       <= w_lo_nxt;
        r_div_zero <= (r_state == S_DIV) && r_dz;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mthi   <= (req_op == OP_MTHI);
      r_signed <= req_signed;
      r_a      <= req_src1;
      r_b      <= req_src2;
      r_cnt    <= CW'(MUL_STAGES - 1);
      r_dsetup <= 1'b1;
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt - CW'(1);
    end else if (r_state == S_DIV) begin
      if (r_dsetup) begin
        r_dsetup <= 1'b0;
        r_rem    <= '0;
        r_quo    <= w_a_abs;
        r_dvs    <= w_b_abs;
        r_qneg   <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
        r_rneg   <= r_signed & r_a[WIDTH-1];
        r_dz     <= (r_b == '0);
        r_early  <= w_early;
        r_cnt    <= CW'(WIDTH - 1);
      end else begin
        r_rem <= w_rem_it;
        r_quo <= w_quo_it;
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO/div_zero/latency queued at issue, checked at done.
module tb_md_unit;
  localparam int W  = 32;
  localparam int MS = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic         req_signed = 1'b0;
  logic [W-1:0] req_src1 = '0;
  logic [W-1:0] req_src2 = '0;
  logic         flush = 1'b0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;

  md_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_signed(req_signed), .req_src1(req_src1), .req_src2(req_src2),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  function automatic exp_t model(input logic [1:0] op, input logic sgn,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t          e;
    logic [63:0]   p;
    longint        q, r;
    logic [W-1:0]  aa, bb;
    e.hi = m_hi; e.lo = m_lo; e.dz = 1'b0; e.lat = 1;
    case (op)
      2'b10: e.hi = a;
      2'b11: e.lo = a;
      2'b00: begin
        if (sgn) p = longint'($signed(a)) * longint'($signed(b));
        else     p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MS;
      end
      default: begin
        e.lat = W + 1;
        if (b == 0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else if (sgn) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
        aa = (sgn && a[W-1]) ? -a : a;
        bb = (sgn && b[W-1]) ? -b : b;
`ifdef MD_DIV_EARLY_EN
        if (b == 0 || aa < bb) e.lat = 2;
`else
        if (aa == bb && b == 0) e.lat = W + 1;
`endif
      end
    endcase
    return e;
  endfunction

  // Called at a negedge; leaves the bench #1 after the accept edge.
  task automatic issue(input logic [1:0] op, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit track);
    req_op = op; req_signed = sgn; req_src1 = a; req_src2 = b; req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL issue_ready: got %b expected 1", req_ready);
    end
    if (track) sb.push_back(model(op, sgn, a, b));
    @(posedge clk); #1;
    req_valid = 1'b0; req_src1 = '1; req_src2 = '1; req_signed = ~sgn;
  endtask

  task automatic wait_done(input string name);
    int   k;
    bit   got;
    exp_t e;
    got = 0;
    for (k = 0; k <= 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1; break; end
    end
    checks++;
    if (!got || sb.size() == 0) begin
      failures++; $display("FAIL %s_timeout: no done within 60 cycles (queue %0d)", name, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      checks += 5;
      if (k !== e.lat) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", name, k, e.lat); end
      if (hi_out !== e.hi) begin failures++; $display("FAIL %s_hi: got %h expected %h", name, hi_out, e.hi); end
      if (lo_out !== e.lo) begin failures++; $display("FAIL %s_lo: got %h expected %h", name, lo_out, e.lo); end
      if (div_zero !== e.dz) begin failures++; $display("FAIL %s_div_zero: got %b expected %b", name, div_zero, e.dz); end
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
        failures++; $display("FAIL %s_idle_on_done: busy=%b ready=%b expected 0/1", name, busy, req_ready);
      end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic check_quiet(input int cycles, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    checks += 2;
    if (seen) begin failures++; $display("FAIL %s_no_done: done seen, expected none", name); end
    if (hi_out !== m_hi || lo_out !== m_lo) begin
      failures++; $display("FAIL %s_hilo_kept: got %h/%h expected %h/%h", name, hi_out, lo_out, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (hi_out !== '0 || lo_out !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        div_zero !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b rdy=%b expected 0 0 0 0 0 1",
               hi_out, lo_out, busy, done, div_zero, req_ready);
    end
  endtask

  task automatic test_mult;
    @(negedge clk);
    issue(2'b00, 1'b1, 32'hFFFF_FFFE, 32'd3, 1);          wait_done("mult_neg2x3");
    issue(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);  wait_done("mult_umax");
    issue(2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, 1);  wait_done("mult_smin");
    issue(2'b00, 1'b1, 32'h0001_2345, 32'hFFFF_0000, 1);  wait_done("mult_mixed");
  endtask

  task automatic test_div;
    @(negedge clk);
    issue(2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2, 1);          wait_done("div_neg7by2");
    issue(2'b01, 1'b0, 32'h1234_5678, 32'd0, 1);          wait_done("div_by_zero");
    issue(2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);  wait_done("div_min_neg1");
    issue(2'b01, 1'b0, 32'd100, 32'd7, 1);                wait_done("div_100by7");
    issue(2'b01, 1'b1, 32'd7, 32'hFFFF_FFFE, 1);          wait_done("div_7byneg2");
    issue(2'b01, 1'b0, 32'd5, 32'd9, 1);                  wait_done("div_5by9");
    issue(2'b01, 1'b1, 32'hFFFF_FFFB, 32'd0, 1);          wait_done("div_sneg_by_zero");
  endtask

  task automatic test_flush_div;
    @(negedge clk);
    issue(2'b01, 1'b0, 32'hCAFE_0001, 32'd3, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL flush_div_idle: busy=%b ready=%b expected 0/1", busy, req_ready);
    end
    check_quiet(40, "flush_div");
  endtask

  task automatic test_flush_commit;
    @(negedge clk);
    issue(2'b00, 1'b0, 32'd1234, 32'd5678, 0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_quiet(6, "flush_commit");
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    issue(2'b10, 1'b0, 32'hDEAD_BEEF, 32'd0, 1);  wait_done("mthi");
    issue(2'b11, 1'b0, 32'h0BAD_F00D, 32'd0, 1);  wait_done("mtlo");
    checks++;
    if (hi_out !== 32'hDEAD_BEEF || lo_out !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL b2b_final: got %h/%h expected deadbeef/0badf00d", hi_out, lo_out);
    end
    flush = 1'b1; req_valid = 1'b1; req_op = 2'b10; req_src1 = 32'h1111_1111;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b expected 0", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL flush_blocks_accept: busy=%b expected 0", busy); end
    check_quiet(4, "flush_blocks");
  endtask

  task automatic test_random;
    logic [1:0]   op;
    logic         sgn;
    logic [W-1:0] a, b;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      op  = 2'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      issue(op, sgn, a, b, 1);
      wait_done("random");
    end
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    issue(2'b01, 1'b1, 32'h7654_3210, 32'd9, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || div_zero !== 1'b0) begin
      failures++; $display("FAIL reset_midop_idle: busy=%b dz=%b expected 0/0", busy, div_zero);
    end
    check_quiet(40, "reset_midop");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_flush_div();
    test_flush_commit();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
